ctrl_wr_staging: RTL
====================

CTRL_WR_STAGING -- requirements
Module: ctrl_wr_staging

Interface
REQ-001 SHALL have parameter DEPTH, default 8, write-burst FIFO depth in entries (power of two).
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding issued writes awaiting data release.
REQ-003 SHALL have parameter DATA_W, default 64, burst payload width (8 beats x 8 bits, beat 0 in [7:0]).
REQ-004 SHALL have ports, clock and reset first:
- CK_t  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_req_vld  in  1  host burst valid.
- wr_req_rdy  out  1  buffer can accept a burst.
- wr_req_data  in  DATA_W  burst payload.
- wr_req_bl  in  4  burst length in beats (8 = BL8, 4 = BC4).
- wr_req_pre  in  2  write preamble in clocks (1 or 2).
- wr_issue  in  1  one-cycle pulse: scheduler put a WRITE command on the bus.
- cwl  in  5  CAS write latency in clocks, static while any write is outstanding.
- out_vld  out  1  one-cycle pulse: burst handed to the DQ/DQS serializer.
- out_data  out  DATA_W  released payload.
- out_bl  out  4  released burst length.
- out_pre  out  2  released preamble.
- level  out  4  FIFO occupancy, 0..DEPTH.
- underflow_err  out  1  sticky: issue with no uncommitted entry.
- overflow_err  out  1  sticky: issue with MAX_OUT already outstanding.

Function
REQ-005 SHALL assert wr_req_rdy combinationally when level < DEPTH; push occurs on a rising edge with wr_req_vld && wr_req_rdy.
REQ-006 SHALL keep uncommitted = level - outstanding; wr_issue with uncommitted = 0 sets underflow_err and is dropped.
REQ-007 SHALL on accepted wr_issue allocate a countdown slot loaded with max(cwl - head_pre, 1), head_pre being the preamble of the oldest uncommitted entry.
REQ-008 SHALL on wr_issue with MAX_OUT slots busy set overflow_err and drop the issue; no slot allocated, FIFO untouched.
REQ-009 SHALL decrement every busy slot each cycle; a slot reaching 0 pops the FIFO head and pulses out_vld for exactly one cycle, out_data/out_bl/out_pre valid in that cycle.
REQ-010 SHALL release in strict issue order; if two slots reach 0 in one cycle the older releases and the younger is held at 0 and releases next cycle.
REQ-011 SHALL hold out_data/out_bl/out_pre at last released values while out_vld is low.
REQ-012 SHALL support simultaneous push and pop in one cycle with level unchanged, including at level = DEPTH (push refused, rdy low) and level = 0 (pop impossible by REQ-006).
REQ-013 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-014 SHALL have per-slot states FREE -> COUNT (on allocation) -> RELEASE (count 0) -> FREE (on pop); RELEASE lasts one cycle unless deferred by REQ-010.
REQ-015 SHALL clear underflow_err and overflow_err only by reset.

Reset
REQ-016 SHALL on reset_n low, asynchronously: empty FIFO, level = 0, all slots FREE, out_vld = 0, out_data = 0, out_bl = 0, out_pre = 0, both errors 0, wr_req_rdy = 1 once released.
REQ-017 SHALL discard bursts pending mid-countdown on reset; no out_vld after reset deassertion without new issue.

Structure
REQ-018 SHALL take wr_data_type, STAGE_DEPTH and STAGE_MAX_OUT from ddr_pkg.
REQ-019 SHALL instantiate one sub-module, ctrl_sync_fifo (parameterised width/depth, push/pop/level), holding the burst entries.

Verification
REQ-020 Push one burst (data 0x0807060504030201, bl 8, pre 1), cwl 9, issue at cycle T -> out_vld exactly at T+8, out_data matches, level 1 -> 0.
REQ-021 Push 8 bursts -> wr_req_rdy low, 9th vld held; issue + pop same cycle -> rdy high next cycle, level stays 8 on concurrent push.
REQ-022 Issue with empty FIFO -> underflow_err 1, no out_vld, level 0.
REQ-023 Push 6, five back-to-back issues, cwl 12 -> 5th sets overflow_err, first four released on four consecutive cycles in push order.
REQ-024 cwl 1, pre 2 -> latency clamped to 1 cycle after issue.
REQ-025 Reset asserted with 3 slots counting -> all outputs zero immediately, no out_vld after release, level 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR controller write path.
// Holds the write-staging defaults, the per-slot countdown state encoding
// and the helper that turns CAS write latency into a release delay.
package ddr_pkg;

  // Default geometry of the write-burst staging buffer
  localparam int STAGE_DEPTH   = 8;
  localparam int STAGE_MAX_OUT = 4;

  // Field widths of one staged burst entry and of the CWL setting
  localparam int ENTRY_BL_W  = 4;
  localparam int ENTRY_PRE_W = 2;
  localparam int CWL_W       = 5;

  // One BL8 burst of x8 data, beat 0 in the low byte
  typedef logic [63:0] wr_data_type;

  // Life cycle of one outstanding-write countdown slot
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_COUNT   = 2'd1,
    SLOT_RELEASE = 2'd2
  } slot_state_t;

  // Clocks from the WRITE command until the burst must reach the
  // serializer: CWL minus the preamble the serializer adds in front,
  // but never less than one clock so a release can always be scheduled.
  function automatic logic [CWL_W-1:0] wr_release_delay(
    input logic [CWL_W-1:0]       cwlVal,
    input logic [ENTRY_PRE_W-1:0] preVal
  );
    logic [CWL_W-1:0] preExt;
    preExt = {{(CWL_W - ENTRY_PRE_W){1'b0}}, preVal};
    if (cwlVal > preExt) begin
      return cwlVal - preExt;
    end
    return CWL_W'(1);
  endfunction

endpackage

// File: rtl/ctrl_sync_fifo.sv
// Single-clock FIFO used to stage write bursts.
// Besides the head entry it exposes a narrow "peek" field of the entry a
// given number of places behind the head, so the owner can look at entries
// that are queued but not yet the next to leave.
module ctrl_sync_fifo
  import ddr_pkg::*;
#(
  parameter int WIDTH  = 70,
  parameter int DEPTH  = 8,
  parameter int PEEK_W = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_pop,
  input  logic [AW-1:0]     i_peekOfs,
  output logic [WIDTH-1:0]  o_headData,
  output logic [PEEK_W-1:0] o_peekData,
  output logic [LW-1:0]     o_level,
  output logic              o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic [AW-1:0]    w_peekIdx;
  logic [WIDTH-1:0] w_peekEntry;
  logic             w_empty;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_doPush    = i_push && !o_full;
  assign w_doPop     = i_pop && !w_empty;
  assign w_peekIdx   = r_rdPtr + i_peekOfs;
  assign w_peekEntry = r_mem[w_peekIdx];
  assign o_headData  = r_mem[r_rdPtr];
  assign o_peekData  = w_peekEntry[PEEK_W-1:0];
  assign o_level     = r_level;

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Occupancy; a push and a pop in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_wr_staging.sv
// Write-data staging between the host and the DQ/DQS serializer.
// Host bursts wait in a FIFO. Each WRITE command the scheduler issues claims
// the oldest unclaimed burst and starts a countdown slot of
// max(CWL - preamble, 1) clocks; when the countdown ends the burst leaves
// the FIFO head with a one-cycle out_vld. Slots are allocated and retired
// as a ring, so releases always come out in issue order.
module ctrl_wr_staging
  import ddr_pkg::*;
#(
  parameter int DEPTH   = STAGE_DEPTH,
  parameter int MAX_OUT = STAGE_MAX_OUT,
  parameter int DATA_W  = $bits(wr_data_type)
) (
  input  logic                   CK_t,
  input  logic                   reset_n,
  input  logic                   wr_req_vld,
  output logic                   wr_req_rdy,
  input  logic [DATA_W-1:0]      wr_req_data,
  input  logic [ENTRY_BL_W-1:0]  wr_req_bl,
  input  logic [ENTRY_PRE_W-1:0] wr_req_pre,
  input  logic                   wr_issue,
  input  logic [CWL_W-1:0]       cwl,
  output logic                   out_vld,
  output logic [DATA_W-1:0]      out_data,
  output logic [ENTRY_BL_W-1:0]  out_bl,
  output logic [ENTRY_PRE_W-1:0] out_pre,
  output logic [3:0]             level,
  output logic                   underflow_err,
  output logic                   overflow_err
);

  localparam int ENTRY_W = DATA_W + ENTRY_BL_W + ENTRY_PRE_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int SW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int BW      = $clog2(MAX_OUT + 1);

  // FIFO side
  logic [ENTRY_W-1:0]     w_pushEntry;
  logic [ENTRY_W-1:0]     w_headEntry;
  logic [DATA_W-1:0]      w_headData;
  logic [ENTRY_BL_W-1:0]  w_headBl;
  logic [ENTRY_PRE_W-1:0] w_headPre;
  logic [ENTRY_PRE_W-1:0] w_peekPre;
  logic [LW-1:0]          w_fifoLevel;
  logic                   w_fifoFull;
  logic                   w_push;

  // Countdown slots
  slot_state_t            r_slotState [MAX_OUT];
  logic [CWL_W-1:0]       r_slotCnt   [MAX_OUT];
  logic [SW-1:0]          r_allocPtr;
  logic [SW-1:0]          r_relPtr;
  logic [BW-1:0]          r_busyCnt;
  logic                   w_slotsFull;
  logic                   w_hasUncommitted;
  logic                   w_issueOk;
  logic                   w_release;
  logic [CWL_W-1:0]       w_issueDelay;

  // Output hold registers and sticky errors
  logic [DATA_W-1:0]      r_holdData;
  logic [ENTRY_BL_W-1:0]  r_holdBl;
  logic [ENTRY_PRE_W-1:0] r_holdPre;
  logic                   r_underflow;
  logic                   r_overflow;

  // Advance a slot ring pointer, wrapping at MAX_OUT
  function automatic logic [SW-1:0] nextSlot(input logic [SW-1:0] ptr);
    return (ptr == SW'(MAX_OUT - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_pushEntry = {wr_req_data, wr_req_bl, wr_req_pre};
  assign w_push      = wr_req_vld && wr_req_rdy;
  assign wr_req_rdy  = !w_fifoFull;
  assign level       = 4'(w_fifoLevel);

  ctrl_sync_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .PEEK_W (ENTRY_PRE_W)
  ) u_burstFifo (
    .clk        (CK_t),
    .rst_n      (reset_n),
    .i_push     (w_push),
    .i_wdata    (w_pushEntry),
    .i_pop      (w_release),
    .i_peekOfs  (AW'(r_busyCnt)),
    .o_headData (w_headEntry),
    .o_peekData (w_peekPre),
    .o_level    (w_fifoLevel),
    .o_full     (w_fifoFull)
  );

  assign w_headData = w_headEntry[ENTRY_W-1:ENTRY_BL_W+ENTRY_PRE_W];
  assign w_headBl   = w_headEntry[ENTRY_PRE_W +: ENTRY_BL_W];
  assign w_headPre  = w_headEntry[ENTRY_PRE_W-1:0];

  // Entries already claimed by a slot sit at the FIFO head, so the oldest
  // unclaimed entry is r_busyCnt places behind it; that is where the peek
  // looks for the preamble that shortens the countdown.
  assign w_slotsFull      = (r_busyCnt == BW'(MAX_OUT));
  assign w_hasUncommitted = (int'(w_fifoLevel) > int'(r_busyCnt));
  assign w_issueOk        = wr_issue && !w_slotsFull && w_hasUncommitted;
  assign w_issueDelay     = wr_release_delay(cwl, w_peekPre);

  // Only the oldest slot may release; younger slots that already reached
  // zero wait in RELEASE until they become the oldest.
  assign w_release = (r_slotState[r_relPtr] == SLOT_RELEASE);

  // While nothing is released the outputs keep showing the last burst
  assign out_vld  = w_release;
  assign out_data = w_release ? w_headData : r_holdData;
  assign out_bl   = w_release ? w_headBl   : r_holdBl;
  assign out_pre  = w_release ? w_headPre  : r_holdPre;

  assign underflow_err = r_underflow;
  assign overflow_err  = r_overflow;

  // Slot state machines: count down, release oldest, allocate on issue.
  // A delay of one goes straight to RELEASE so the burst leaves on the
  // clock right after the WRITE command.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_slotState[i] <= SLOT_FREE;
        r_slotCnt[i]   <= '0;
      end
      r_allocPtr <= '0;
      r_relPtr   <= '0;
      r_busyCnt  <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (r_slotState[i] == SLOT_COUNT) begin
          if (r_slotCnt[i] <= CWL_W'(1)) begin
            r_slotState[i] <= SLOT_RELEASE;
            r_slotCnt[i]   <= '0;
          end else begin
            r_slotCnt[i] <= r_slotCnt[i] - 1'b1;
          end
        end
      end
      if (w_release) begin
        r_slotState[r_relPtr] <= SLOT_FREE;
        r_relPtr              <= nextSlot(r_relPtr);
      end
      if (w_issueOk) begin
        r_slotState[r_allocPtr] <= (w_issueDelay == CWL_W'(1)) ? SLOT_RELEASE : SLOT_COUNT;
        r_slotCnt[r_allocPtr]   <= w_issueDelay - 1'b1;
        r_allocPtr              <= nextSlot(r_allocPtr);
      end
      case ({w_issueOk, w_release})
        2'b10:   r_busyCnt <= r_busyCnt + 1'b1;
        2'b01:   r_busyCnt <= r_busyCnt - 1'b1;
        default: r_busyCnt <= r_busyCnt;
      endcase
    end
  end

  // Capture each released burst so the outputs can hold it afterwards
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_holdData <= '0;
      r_holdBl   <= '0;
      r_holdPre  <= '0;
    end else if (w_release) begin
      r_holdData <= w_headData;
      r_holdBl   <= w_headBl;
      r_holdPre  <= w_headPre;
    end
  end

  // Sticky error flags for dropped WRITE commands; only reset clears them
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (wr_issue && !w_hasUncommitted) begin
        r_underflow <= 1'b1;
      end
      if (wr_issue && w_slotsFull) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
